// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch: PC-driven memory reads, in-order response buffer, flush on PC load
// Optional misaligned-fetch fault entries when IF_MISALIGN_CHECK_EN is defined.
module if_fetch_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OSTD   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic [XLEN-1:0] pc_addr,
  input  logic            pc_ovf,
  input  logic            pc_load,
  output logic            pc_enable,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_addr,
  output logic            instr_fault,
  input  logic            instr_ready
);
  localparam int OW = $clog2(MAX_OSTD + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int AW = (MAX_OSTD > 1) ? $clog2(MAX_OSTD) : 1;
  localparam logic [OW-1:0] MAX_C   = OW'(MAX_OSTD);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] AQ_LAST = AW'(MAX_OSTD - 1);

  logic [OW-1:0]   ostd_q, ostd_d, discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
  logic [XLEN-1:0] aq_q [MAX_OSTD];
  logic [XLEN-1:0] buf_addr_q [FIFO_DEPTH];
  logic [XLEN-1:0] buf_data_q [FIFO_DEPTH];
  logic            issue, rsp, rsp_push, push, pop, misalign, fault_push;

  // Credit rule: every in-flight read already owns a buffer slot, so the buffer cannot overflow.
  assign mem_req = rst_n & !pc_load & !pc_ovf & !misalign & (ostd_q < MAX_C) &
                   ((SW'(ostd_q) + SW'(count_q)) < SW'(FIFO_DEPTH));
  assign issue     = mem_req & mem_gnt;
  assign pc_enable = issue;
  assign mem_addr  = pc_addr;

  assign rsp      = mem_rvalid & (ostd_q != '0);
  assign rsp_push = rsp & (discard_q == '0) & !pc_load;
  assign push     = rsp_push | fault_push;
  assign pop      = instr_valid & instr_ready & !pc_load;

  assign instr_valid = (count_q != '0);
  assign instr_data  = buf_data_q[rd_ptr_q];
  assign instr_addr  = buf_addr_q[rd_ptr_q];

`ifdef IF_MISALIGN_CHECK_EN
  logic                  stall_q, stall_d;
  logic [FIFO_DEPTH-1:0] buf_fault_q;

  // A misaligned PC yields one fault entry, then fetch waits for a redirect.
  assign misalign    = (pc_addr[1:0] != 2'b00);
  assign fault_push  = misalign & !stall_q & !pc_load & (ostd_q == '0) & (count_q != DEPTH_C);
  assign stall_d     = pc_load ? 1'b0 : (stall_q | fault_push);
  assign instr_fault = buf_fault_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q     <= 1'b0;
      buf_fault_q <= '0;
    end else if (clk_en) begin
      stall_q <= stall_d;
      if (push) buf_fault_q[wr_ptr_q] <= fault_push;
    end
  end
`else
  assign misalign    = 1'b0;
  assign fault_push  = 1'b0;
  assign instr_fault = 1'b0;
`endif

  always_comb begin
    ostd_d    = ostd_q;
    discard_d = discard_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    aq_rd_d   = aq_rd_q;
    aq_wr_d   = aq_wr_q;
    if (issue) aq_wr_d = (aq_wr_q == AQ_LAST) ? '0 : aq_wr_q + 1'b1;
    if (rsp)   aq_rd_d = (aq_rd_q == AQ_LAST) ? '0 : aq_rd_q + 1'b1;
    case ({issue, rsp})
      2'b10:   ostd_d = ostd_q + 1'b1;
      2'b01:   ostd_d = ostd_q - 1'b1;
      default: ostd_d = ostd_q;
    endcase
    if (pc_load) begin
      // Every read still outstanding after this cycle belongs to the old stream.
      discard_d = ostd_q - OW'(rsp);
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      if (rsp && (discard_q != '0)) discard_d = discard_q - 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ostd_q    <= '0;
      discard_q <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      aq_rd_q   <= '0;
      aq_wr_q   <= '0;
      for (int i = 0; i < MAX_OSTD; i++) aq_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else if (clk_en) begin
      ostd_q    <= ostd_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      aq_rd_q   <= aq_rd_d;
      aq_wr_q   <= aq_wr_d;
      if (issue) aq_q[aq_wr_q] <= pc_addr;
      if (push) begin
        buf_addr_q[wr_ptr_q] <= rsp_push ? aq_q[aq_rd_q] : pc_addr;
        buf_data_q[wr_ptr_q] <= rsp_push ? mem_rdata : '0;
      end
    end
  end

  push_to_full_a: assert property (@(posedge clk) disable iff (!rst_n || !clk_en)
    !(push && (count_q == DEPTH_C)));
  rvalid_idle_a: assert property (@(posedge clk) disable iff (!rst_n || !clk_en)
    !(mem_rvalid && (ostd_q == '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit with a transaction-level model
module tb_if_fetch_unit;
  localparam int XLEN       = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OSTD   = 2;

  logic            clk = 1'b0;
  logic            rst_n, clk_en, pc_ovf, pc_load, pc_enable, mem_req, mem_gnt, mem_rvalid;
  logic            instr_valid, instr_fault, instr_ready;
  logic [XLEN-1:0] pc_addr, mem_addr, mem_rdata, instr_data, instr_addr;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic fault; } ent_t;

  pend_t       pend[$];
  ent_t        m_buf[$];
  logic [31:0] m_fl_addr[$];
  bit          m_fl_stale[$];
  bit          m_stall = 1'b0;
  logic [31:0] popped[$];
  int          pop_cyc[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, lat = 1, grant_cnt = 0;
  bit          rsp_en = 1'b1;
  logic [31:0] pc_nxt = '0, load_addr = '0;

  if_fetch_unit #(.XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OSTD(MAX_OSTD)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .pc_addr(pc_addr), .pc_ovf(pc_ovf), .pc_load(pc_load), .pc_enable(pc_enable),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr(instr_addr),
    .instr_fault(instr_fault), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_00C3;
  endfunction

  // Memory: answers each granted read in order, lat cycles after its grant.
  task automatic drive_rsp();
    if (rsp_en && clk_en && rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = word_of(pend[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    pc_addr = pc_nxt;
    drive_rsp();
  endtask

  task automatic drain();
    pc_ovf      = 1'b1;
    instr_ready = 1'b1;
    repeat (12) step();
  endtask

  // Model + compare + environment bookkeeping, all away from the active edge.
  always @(negedge clk) begin
    bit          exp_req, grant, resp, pop, fpush, st;
    int          nfl, nbuf;
    logic [31:0] a;
    if (!rst_n) begin
      m_buf.delete();
      m_fl_addr.delete();
      m_fl_stale.delete();
      pend.delete();
      m_stall = 1'b0;
      pc_nxt  = '0;
    end else begin
      nfl     = m_fl_addr.size();
      nbuf    = m_buf.size();
      exp_req = !pc_load && !pc_ovf && (nfl < MAX_OSTD) && (nfl + nbuf < FIFO_DEPTH);
      fpush   = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      if (pc_addr[1:0] != 2'b00) begin
        exp_req = 1'b0;
        fpush   = !m_stall && !pc_load && (nfl == 0) && (nbuf < FIFO_DEPTH);
      end
`endif
      chk("mem_req", mem_req, exp_req);
      chk("pc_enable", pc_enable, exp_req && mem_gnt);
      chk("mem_addr", mem_addr, pc_addr);
      chk("instr_valid", instr_valid, nbuf > 0);
      if (nbuf > 0) begin
        chk("instr_addr", instr_addr, m_buf[0].addr);
        chk("instr_data", instr_data, m_buf[0].data);
        chk("instr_fault", instr_fault, m_buf[0].fault);
      end
      pc_nxt = pc_addr;
      if (clk_en) begin
        grant = exp_req && mem_gnt;
        resp  = mem_rvalid && (nfl > 0);
        pop   = (nbuf > 0) && instr_ready && !pc_load;
        if (pop) begin
          popped.push_back(m_buf[0].addr);
          pop_cyc.push_back(cyc);
          void'(m_buf.pop_front());
        end
        if (resp) begin
          st = m_fl_stale.pop_front();
          a  = m_fl_addr.pop_front();
          if (!st && !pc_load) m_buf.push_back('{a, mem_rdata, 1'b0});
        end
        if (fpush) begin
          m_buf.push_back('{pc_addr, 32'h0, 1'b1});
          m_stall = 1'b1;
        end
        if (pc_load) begin
          m_buf.delete();
          foreach (m_fl_stale[i]) m_fl_stale[i] = 1'b1;
          m_stall = 1'b0;
        end
        if (grant) begin
          m_fl_addr.push_back(pc_addr);
          m_fl_stale.push_back(1'b0);
        end
        if (mem_rvalid && pend.size() > 0) void'(pend.pop_front());
        if (mem_req && mem_gnt) begin
          pend.push_back('{mem_addr, cyc + lat});
          grant_cnt++;
        end
        if (pc_load)        pc_nxt = load_addr;
        else if (pc_enable) pc_nxt = pc_addr + 32'd4;
      end
    end
  end

  initial begin
    int          g0, g1;
    logic [31:0] a0, hold;
    rst_n = 1'b0; clk_en = 1'b1; pc_addr = '0; pc_ovf = 1'b0; pc_load = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0; instr_ready = 1'b1;
    step();
    step();
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr_data", instr_data, 32'h0);
    chk("rst_instr_addr", instr_addr, 32'h0);
    chk("rst_instr_fault", instr_fault, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);

    // Streaming from PC 0 with one-cycle memory latency
    rst_n = 1'b1;
    popped.delete();
    pop_cyc.delete();
    for (int i = 0; i < 20 && popped.size() < 3; i++) step();
    if (popped.size() < 3) timeout_fail("stream_first3");
    else begin
      chk("stream_addr0", popped[0], 32'h0);
      chk("stream_addr1", popped[1], 32'h4);
      chk("stream_addr2", popped[2], 32'h8);
      chk("stream_rate01", pop_cyc[1] - pop_cyc[0], 32'd1);
      chk("stream_rate12", pop_cyc[2] - pop_cyc[1], 32'd1);
    end

    // Clock-enable freeze mid-stream
    step();
    clk_en = 1'b0; mem_gnt = 1'b0; drive_rsp();
    #1 hold = instr_addr;
    repeat (3) step();
    chk("freeze_head", instr_addr, hold);
    clk_en = 1'b1; mem_gnt = 1'b1; drive_rsp();
    repeat (4) step();

    // Decode stalled: credit limit allows exactly FIFO_DEPTH grants
    drain();
    g0 = grant_cnt;
    instr_ready = 1'b0;
    pc_ovf = 1'b0;
    repeat (12) step();
    #1;
    chk("full_grants", grant_cnt - g0, 32'd4);
    chk("full_no_req", mem_req, 1'b0);
    chk("full_valid", instr_valid, 1'b1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    repeat (6) step();
    chk("pop_one_regrant", grant_cnt - g0, 32'd5);

    // Flush with two reads in flight
    drain();
    lat = 4;
    pc_ovf = 1'b0;
    g0 = grant_cnt;
    step();
    step();
    chk("flush_inflight", grant_cnt - g0, 32'd2);
    pc_load = 1'b1;
    load_addr = 32'h100;
    popped.delete();
    step();
    pc_load = 1'b0;
    for (int i = 0; i < 30 && popped.size() < 1; i++) step();
    if (popped.size() < 1) timeout_fail("flush_first");
    else chk("flush_first_addr", popped[0], 32'h100);
    lat = 1;

    // Grant withheld: request held, PC steady; one grant advances PC once
    drain();
    a0 = pc_addr;
    g0 = grant_cnt;
    mem_gnt = 1'b0;
    pc_ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("nognt_req", mem_req, 1'b1);
      chk("nognt_pc_en", pc_enable, 1'b0);
      chk("nognt_addr", mem_addr, a0);
      step();
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #1;
    chk("gnt_pc_adv", pc_addr, a0 + 32'd4);
    repeat (3) step();
    chk("gnt_single", grant_cnt - g0, 32'd1);
    mem_gnt = 1'b1;

    // PC overflow with two reads in flight: both delivered, nothing new issued
    drain();
    lat = 3;
    pc_ovf = 1'b0;
    popped.delete();
    g0 = grant_cnt;
    step();
    step();
    pc_ovf = 1'b1;
    g1 = grant_cnt;
    chk("ovf_inflight", g1 - g0, 32'd2);
    repeat (10) step();
    #1;
    chk("ovf_delivered", popped.size(), 32'd2);
    chk("ovf_no_grant", grant_cnt - g1, 32'd0);
    chk("ovf_no_req", mem_req, 1'b0);
    lat = 1;

`ifdef IF_MISALIGN_CHECK_EN
    // Misaligned redirect: one fault entry, no memory request
    drain();
    pc_ovf = 1'b0;
    pc_load = 1'b1;
    load_addr = 32'h102;
    step();
    pc_load = 1'b0;
    instr_ready = 1'b0;
    repeat (4) step();
    #1;
    chk("mis_no_req", mem_req, 1'b0);
    chk("mis_valid", instr_valid, 1'b1);
    chk("mis_fault", instr_fault, 1'b1);
    chk("mis_addr", instr_addr, 32'h102);
    chk("mis_data", instr_data, 32'h0);
    instr_ready = 1'b1;
    repeat (4) step();
    #1;
    chk("mis_once", instr_valid, 1'b0);
    pc_load = 1'b1;
    load_addr = 32'h200;
    step();
    pc_load = 1'b0;
    repeat (4) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
